clock_div_bank: RTL and testbench

Multi-channel programmable clock divider bank, the parametrised successor to the single-channel divider/reset staging in the clock routing block. All NCH channels derive registered, glitch-free divided clocks from dll_clk. Each channel has:
- its own divisor, adopted only at period boundaries
- its own enable, with clean stop at end of period
- a per-channel staged reset release
A global realign starts all enabled channels in phase. The block sits after the DLL/clock mux and feeds auxiliary and peripheral clock domains.

---
 rtl/clock_div_bank.sv | 164 ++++++++++++++++
 tb/tb_clock_div_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_bank.sv
// clock_div_bank
//   Bank of NCH programmable clock dividers, all clocked from dll_clk.
//   Each channel produces a registered divided clock, adopts a new divisor
//   only at period boundaries, stops cleanly at the end of a period, and has
//   its own staged active-low reset that releases after RST_STAGES rising
//   edges of its output. A global realign restarts all enabled channels in phase.
//
// Ports
//   dll_clk      in   source clock, all state on posedge
//   resetb       in   asynchronous active-low master reset
//   div_in       in   NCH*WIDTH divisors, channel i at [i*WIDTH +: WIDTH]
//                     (0 and 1 clamp to 2)
//   enable       in   NCH per-channel run requests
//   realign      in   synchronous pulse, phase-aligns enabled channels
//   ext_reset    in   positive-sense reset, combinational into resetb_sync
//   clk_out      out  NCH divided clocks (registered)
//   div_ack      out  NCH one-cycle pulses when a divisor is adopted
//   running      out  NCH channel is in RUN
//   resetb_sync  out  NCH staged active-low channel resets
module clock_div_bank #(
  parameter int NCH        = 4,
  parameter int WIDTH      = 8,
  parameter int RST_STAGES = 3
) (
  input  logic                 dll_clk,
  input  logic                 resetb,
  input  logic [NCH*WIDTH-1:0] div_in,
  input  logic [NCH-1:0]       enable,
  input  logic                 realign,
  input  logic                 ext_reset,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       div_ack,
  output logic [NCH-1:0]       running,
  output logic [NCH-1:0]       resetb_sync
);

  localparam int SW = (RST_STAGES > 0) ? $clog2(RST_STAGES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ALIGN = 2'd2
  } state_t;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_act, w_act_nxt;
    logic [SW-1:0]    r_stage, w_stage_nxt;
    logic             r_out, w_out_nxt;
    logic             r_ack, w_ack_nxt;
    logic             r_prev;

    logic [WIDTH-1:0] w_div;
    logic [WIDTH-1:0] w_nclamp;
    logic [WIDTH:0]   w_hi;
    logic [WIDTH:0]   w_cnt_inc;
    logic             w_term;

    assign w_div     = div_in[g*WIDTH +: WIDTH];
    assign w_nclamp  = (w_div < WIDTH'(2)) ? WIDTH'(2) : w_div;
    // One extra bit so act = 2^WIDTH-1 does not wrap.
    assign w_hi      = ({1'b0, r_act} + (WIDTH+1)'(1)) >> 1;
    assign w_cnt_inc = {1'b0, r_cnt} + (WIDTH+1)'(1);
    assign w_term    = (w_cnt_inc == {1'b0, r_act});

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_act_nxt   = r_act;
      w_out_nxt   = r_out;
      w_ack_nxt   = 1'b0;
      w_stage_nxt = r_stage;

      case (r_state)
        S_IDLE: begin
          w_out_nxt = 1'b0;
          if (realign && enable[g]) begin
            w_state_nxt = S_ALIGN;
            w_cnt_nxt   = '0;
          end else if (enable[g]) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
            w_act_nxt   = w_nclamp;
            w_out_nxt   = 1'b1;
            w_ack_nxt   = 1'b1;
          end
        end
        S_RUN: begin
          if (realign) begin
            w_state_nxt = S_ALIGN;
            w_cnt_nxt   = '0;
            w_out_nxt   = 1'b0;
          end else if (w_term) begin
            if (enable[g]) begin
              w_cnt_nxt = '0;
              w_act_nxt = w_nclamp;
              w_out_nxt = 1'b1;
              w_ack_nxt = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
              w_out_nxt   = 1'b0;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc[WIDTH-1:0];
            w_out_nxt = (w_cnt_inc < w_hi);
          end
        end
        S_ALIGN: begin
          w_out_nxt = 1'b0;
          w_cnt_nxt = '0;
          if (!realign) begin
            if (enable[g]) begin
              w_state_nxt = S_RUN;
              w_act_nxt   = w_nclamp;
              w_out_nxt   = 1'b1;
              w_ack_nxt   = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_out_nxt   = 1'b0;
        end
      endcase

      // Stage counts visible rising edges of the registered output, so the
      // channel reset releases in the cycle after the final counted edge.
      if (r_state == S_IDLE) begin
        w_stage_nxt = SW'(RST_STAGES);
      end else if (r_out && !r_prev && (r_stage != '0)) begin
        w_stage_nxt = r_stage - SW'(1);
      end
    end

    always_ff @(posedge dll_clk or negedge resetb) begin
      if (!resetb) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_act   <= WIDTH'(2);
        r_stage <= SW'(RST_STAGES);
        r_out   <= 1'b0;
        r_ack   <= 1'b0;
        r_prev  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_act   <= w_act_nxt;
        r_stage <= w_stage_nxt;
        r_out   <= w_out_nxt;
        r_ack   <= w_ack_nxt;
        r_prev  <= r_out;
      end
    end

    assign clk_out[g]     = r_out;
    assign div_ack[g]     = r_ack;
    assign running[g]     = (r_state == S_RUN);
    assign resetb_sync[g] = (r_stage == '0) & ~ext_reset & (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_clock_div_bank.sv
module tb_clock_div_bank;
  localparam int NCH        = 4;
  localparam int WIDTH      = 8;
  localparam int RST_STAGES = 3;

  logic                 dll_clk = 1'b0;
  logic                 resetb;
  logic [NCH*WIDTH-1:0] div_in;
  logic [NCH-1:0]       enable;
  logic                 realign;
  logic                 ext_reset;
  logic [NCH-1:0]       clk_out;
  logic [NCH-1:0]       div_ack;
  logic [NCH-1:0]       running;
  logic [NCH-1:0]       resetb_sync;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    string      tag;
    logic [3:0] clk;
    logic [3:0] ack;
    logic [3:0] run;
    logic [3:0] rs;
  } exp_t;

  exp_t sb[$];

  clock_div_bank #(
    .NCH(NCH),
    .WIDTH(WIDTH),
    .RST_STAGES(RST_STAGES)
  ) dut (
    .dll_clk(dll_clk),
    .resetb(resetb),
    .div_in(div_in),
    .enable(enable),
    .realign(realign),
    .ext_reset(ext_reset),
    .clk_out(clk_out),
    .div_ack(div_ack),
    .running(running),
    .resetb_sync(resetb_sync)
  );

  always #5 dll_clk = ~dll_clk;

  // Ideal divided-clock shape at offset m into a stream started at ratio n.
  function automatic logic pclk(int n, int m);
    int hi;
    hi = (n + 1) / 2;
    return ((m % n) < hi);
  endfunction

  function automatic logic pack(int n, int m);
    return ((m % n) == 0);
  endfunction

  task automatic push(string tag, logic [3:0] c, logic [3:0] a, logic [3:0] r, logic [3:0] s);
    exp_t e;
    e.tag = tag; e.clk = c; e.ack = a; e.run = r; e.rs = s;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL sb_empty: no expectation queued, got clk=%b", clk_out);
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    assert (clk_out === e.clk) else begin
      n_bad++; $error("FAIL %s clk_out got %b want %b", e.tag, clk_out, e.clk);
    end
    n_cmp++;
    assert (div_ack === e.ack) else begin
      n_bad++; $error("FAIL %s div_ack got %b want %b", e.tag, div_ack, e.ack);
    end
    n_cmp++;
    assert (running === e.run) else begin
      n_bad++; $error("FAIL %s running got %b want %b", e.tag, running, e.run);
    end
    n_cmp++;
    assert (resetb_sync === e.rs) else begin
      n_bad++; $error("FAIL %s resetb_sync got %b want %b", e.tag, resetb_sync, e.rs);
    end
  endtask

  task automatic cyc();
    @(posedge dll_clk);
    @(negedge dll_clk);
    check_now();
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    enable = '0;
    realign = 1'b0;
    ext_reset = 1'b0;
    @(negedge dll_clk);
    resetb = 1'b1;
  endtask

  initial begin
    logic [3:0] c, a, r, s;
    logic [9:0] e_clk;
    logic [9:0] e_ack;
    int nr[4];

    resetb = 1'b0; enable = '0; realign = 1'b0; ext_reset = 1'b0; div_in = '0;
    @(negedge dll_clk);

    // Reset held while inputs toggle: everything stays low.
    for (int i = 0; i < 4; i++) begin
      enable  = i[0] ? '1 : '0;
      realign = i[1];
      push("rst_hold", 4'h0, 4'h0, 4'h0, 4'h0);
      cyc();
    end
    resetb = 1'b1; enable = '0; realign = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("rst_release", 4'h0, 4'h0, 4'h0, 4'h0);
      cyc();
    end

    // Four ratios together, ch3 clamped from 0 to 2; staged reset per ratio.
    nr = '{2, 3, 5, 2};
    div_in = {8'd0, 8'd5, 8'd3, 8'd2};
    enable = '1;
    for (int k = 0; k < 14; k++) begin
      for (int ch = 0; ch < 4; ch++) begin
        c[ch] = pclk(nr[ch], k);
        a[ch] = pack(nr[ch], k);
        r[ch] = 1'b1;
        s[ch] = (k >= 2 * nr[ch] + 1);
      end
      push("ratios", c, a, r, s);
      cyc();
    end

    // Async reset mid-operation takes effect without a clock edge.
    resetb = 1'b0;
    #1;
    push("async_rst", 4'h0, 4'h0, 4'h0, 4'h0);
    check_now();
    @(negedge dll_clk);
    enable = '0;
    resetb = 1'b1;
    push("post_async", 4'h0, 4'h0, 4'h0, 4'h0);
    cyc();

    // Reprogram ch1 from 5 to 4 at cnt=1: current period completes first.
    div_in = {8'd0, 8'd0, 8'd5, 8'd0};
    enable = 4'b0010;
    e_clk = 10'b1001100111;
    e_ack = 10'b1000100001;
    for (int k = 0; k < 10; k++) begin
      push("reprog", {2'b00, e_clk[k], 1'b0}, {2'b00, e_ack[k], 1'b0}, 4'b0010, 4'b0000);
      cyc();
      if (k == 1) div_in[15:8] = 8'd4;
    end
    do_reset();

    // Disable ch2 (ratio 6) at cnt=1 of a later period: period completes.
    div_in = {8'd0, 8'd6, 8'd0, 8'd0};
    enable = 4'b0100;
    for (int k = 0; k < 26; k++) begin
      c = 4'h0; a = 4'h0; r = 4'h0; s = 4'h0;
      c[2] = (k < 24) && pclk(6, k);
      a[2] = (k < 24) && pack(6, k);
      r[2] = (k < 24);
      s[2] = (k >= 13) && (k < 24);
      push("disable", c, a, r, s);
      cyc();
      if (k == 19) enable = 4'b0000;
    end
    do_reset();

    // Realign ch0 (ratio 3) and ch1 (ratio 4) started one cycle apart,
    // then an ext_reset pulse of two cycles.
    div_in = {8'd0, 8'd0, 8'd4, 8'd3};
    enable = 4'b0001;
    for (int k = 0; k < 17; k++) begin
      if (k == 1) enable = 4'b0011;
      realign   = (k == 6);
      ext_reset = (k == 13) || (k == 14);
      c = 4'h0; a = 4'h0; r = 4'h0; s = 4'h0;
      if (k < 6) begin
        c[0] = pclk(3, k); a[0] = pack(3, k); r[0] = 1'b1;
        if (k >= 1) begin
          c[1] = pclk(4, k - 1); a[1] = pack(4, k - 1); r[1] = 1'b1;
        end
      end else if (k >= 7) begin
        c[0] = pclk(3, k - 7); a[0] = pack(3, k - 7); r[0] = 1'b1;
        c[1] = pclk(4, k - 7); a[1] = pack(4, k - 7); r[1] = 1'b1;
      end
      s[0] = (k >= 8) && !ext_reset;
      s[1] = (k >= 8) && !ext_reset;
      push("realign", c, a, r, s);
      cyc();
    end
    realign = 1'b0;
    ext_reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
